// File: rtl/ecc_jacobian_to_affine.sv
// Jacobian-to-affine converter over GF(p): x = X*Z^-2, y = Y*Z^-3.
// Z^-1 comes from Z^(p-2) using left-to-right square-and-multiply.
// Every product goes through one shared modular_multiplication instance.

// Interleaved MSB-first modular multiplier: r = a*b mod m.
// DIGIT_BITS bits of b are consumed per cycle.
// ready rises once the product is valid and stays high until the next start.
module modular_multiplication #(
  parameter int WIDTH      = 256,
  parameter int DIGIT_BITS = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] m,
  output logic             ready,
  output logic [WIDTH-1:0] product
);
  localparam int STEPS = WIDTH / DIGIT_BITS;
  localparam int CW    = $clog2(STEPS + 1);

  logic             busy_q,  busy_d;
  logic             ready_q, ready_d;
  logic [CW-1:0]    cnt_q,   cnt_d;
  logic [WIDTH-1:0] r_q,     r_d;
  logic [WIDTH-1:0] a_q,     a_d;
  logic [WIDTH-1:0] b_q,     b_d;
  logic [WIDTH-1:0] m_q,     m_d;

  // Partial remainder after each bit processed in this cycle; every stage stays < m.
  logic [WIDTH-1:0] stage_r [0:DIGIT_BITS];
  assign stage_r[0] = r_q;

  genvar gi;
  generate
    for (gi = 0; gi < DIGIT_BITS; gi++) begin : g_step
      logic [WIDTH:0]   dbl;
      logic [WIDTH:0]   sum;
      logic [WIDTH-1:0] dbl_red;
      logic [WIDTH-1:0] addend;
      // r = 2r mod m, then r = r + a*bit mod m; a single conditional subtract suffices each time.
      assign dbl     = {stage_r[gi], 1'b0};
      assign dbl_red = (dbl >= {1'b0, m_q}) ? WIDTH'(dbl - {1'b0, m_q}) : dbl[WIDTH-1:0];
      assign addend  = b_q[WIDTH-1-gi] ? a_q : '0;
      assign sum     = {1'b0, dbl_red} + {1'b0, addend};
      assign stage_r[gi+1] = (sum >= {1'b0, m_q}) ? WIDTH'(sum - {1'b0, m_q}) : sum[WIDTH-1:0];
    end
  endgenerate

  // Load operands on start, then step through b until all digits are consumed.
  always_comb begin
    busy_d  = busy_q;
    ready_d = ready_q;
    cnt_d   = cnt_q;
    r_d     = r_q;
    a_d     = a_q;
    b_d     = b_q;
    m_d     = m_q;
    if (start) begin
      a_d     = a;
      b_d     = b;
      m_d     = m;
      r_d     = '0;
      cnt_d   = CW'(STEPS);
      busy_d  = 1'b1;
      ready_d = 1'b0;
    end else if (busy_q) begin
      r_d   = stage_r[DIGIT_BITS];
      b_d   = b_q << DIGIT_BITS;
      cnt_d = cnt_q - CW'(1);
      if (cnt_q == CW'(1)) begin
        busy_d  = 1'b0;
        ready_d = 1'b1;
      end
    end
  end

  // Multiplier state registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy_q  <= 1'b0;
      ready_q <= 1'b0;
      cnt_q   <= '0;
      r_q     <= '0;
      a_q     <= '0;
      b_q     <= '0;
      m_q     <= '0;
    end else begin
      busy_q  <= busy_d;
      ready_q <= ready_d;
      cnt_q   <= cnt_d;
      r_q     <= r_d;
      a_q     <= a_d;
      b_q     <= b_d;
      m_q     <= m_d;
    end
  end

  assign ready   = ready_q;
  assign product = r_q;
endmodule

module ecc_jacobian_to_affine #(
  parameter int WIDTH = 256
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic [WIDTH-1:0] p,
  input  logic [WIDTH-1:0] X,
  input  logic [WIDTH-1:0] Y,
  input  logic [WIDTH-1:0] Z,
  output logic [WIDTH-1:0] x_aff,
  output logic [WIDTH-1:0] y_aff,
  output logic             o_inf,
  output logic             o_busy,
  output logic             o_done
);
  localparam int IW        = $clog2(WIDTH);
  localparam int MUL_DIGIT = (WIDTH % 4 == 0) ? 4 : 1;

  typedef enum logic [3:0] {
    S_IDLE, S_CHK, S_SQR, S_MUL, S_ZI2, S_XA, S_ZI3, S_YA, S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] p_q, p_d, x_q, x_d, y_q, y_d, z_q, z_d, e_q, e_d;
  logic [WIDTH-1:0] acc_q, acc_d, t2_q, t2_d, t3_q, t3_d;
  logic [WIDTH-1:0] x_aff_q, x_aff_d, y_aff_q, y_aff_d;
  logic             inf_q, inf_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic             mul_wait_q, mul_wait_d;

  logic             mul_start;
  logic             mul_ready;
  logic             mul_done;
  logic             mul_state;
  logic [WIDTH-1:0] mul_a, mul_b, mul_p;

  modular_multiplication #(
    .WIDTH      (WIDTH),
    .DIGIT_BITS (MUL_DIGIT)
  ) u_mul (
    .clk     (i_clk),
    .rst_n   (~i_rst),
    .start   (mul_start),
    .a       (mul_a),
    .b       (mul_b),
    .m       (p_q),
    .ready   (mul_ready),
    .product (mul_p)
  );

  // A product is taken only once the issue cycle has passed, so a stale ready is never used.
  assign mul_state = (state_q == S_SQR) || (state_q == S_MUL) || (state_q == S_ZI2) ||
                     (state_q == S_XA)  || (state_q == S_ZI3) || (state_q == S_YA);
  assign mul_done  = mul_wait_q & mul_ready;

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_rst) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic: multiply states advance only when their product is captured.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (i_start) state_d = S_CHK;
      S_CHK:  state_d = (z_q == '0) ? S_DONE : S_SQR;
      S_SQR: if (mul_done) begin
        if (e_q[idx_q])          state_d = S_MUL;
        else if (idx_q == '0)    state_d = S_ZI2;
        else                     state_d = S_SQR;
      end
      S_MUL: if (mul_done) state_d = (idx_q == '0) ? S_ZI2 : S_SQR;
      S_ZI2: if (mul_done) state_d = S_XA;
      S_XA:  if (mul_done) state_d = S_ZI3;
      S_ZI3: if (mul_done) state_d = S_YA;
      S_YA:  if (mul_done) state_d = S_DONE;
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output logic: multiplier issue and operand selection, status flags.
  always_comb begin
    mul_start = mul_state & ~mul_wait_q;
    mul_a     = acc_q;
    mul_b     = acc_q;
    case (state_q)
      S_MUL: mul_b = z_q;
      S_XA:  begin mul_a = x_q;  mul_b = t2_q;  end
      S_ZI3: begin mul_a = t2_q; mul_b = acc_q; end
      S_YA:  begin mul_a = y_q;  mul_b = t3_q;  end
      default: ;
    endcase
    o_busy = (state_q != S_IDLE);
    o_done = (state_q == S_DONE);
  end

  // Datapath updates: input latch, exponent walk and product captures.
  always_comb begin
    p_d        = p_q;
    x_d        = x_q;
    y_d        = y_q;
    z_d        = z_q;
    e_d        = e_q;
    acc_d      = acc_q;
    t2_d       = t2_q;
    t3_d       = t3_q;
    x_aff_d    = x_aff_q;
    y_aff_d    = y_aff_q;
    inf_d      = inf_q;
    idx_d      = idx_q;
    mul_wait_d = mul_wait_q;
    if (mul_start)     mul_wait_d = 1'b1;
    else if (mul_done) mul_wait_d = 1'b0;
    case (state_q)
      S_IDLE: if (i_start) begin
        p_d = p;
        x_d = X;
        y_d = Y;
        z_d = Z;
        e_d = p - WIDTH'(2);
      end
      S_CHK: begin
        if (z_q == '0) begin
          x_aff_d = '0;
          y_aff_d = '0;
          inf_d   = 1'b1;
        end else begin
          acc_d = WIDTH'(1);
          idx_d = IW'(WIDTH - 1);
        end
      end
      S_SQR: if (mul_done) begin
        acc_d = mul_p;
        if (!e_q[idx_q] && (idx_q != '0)) idx_d = idx_q - IW'(1);
      end
      S_MUL: if (mul_done) begin
        acc_d = mul_p;
        if (idx_q != '0) idx_d = idx_q - IW'(1);
      end
      S_ZI2: if (mul_done) t2_d = mul_p;
      S_XA:  if (mul_done) x_aff_d = mul_p;
      S_ZI3: if (mul_done) t3_d = mul_p;
      S_YA:  if (mul_done) begin
        y_aff_d = mul_p;
        inf_d   = 1'b0;
      end
      default: ;
    endcase
  end

  // Datapath registers, all cleared by reset.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      p_q        <= '0;
      x_q        <= '0;
      y_q        <= '0;
      z_q        <= '0;
      e_q        <= '0;
      acc_q      <= '0;
      t2_q       <= '0;
      t3_q       <= '0;
      x_aff_q    <= '0;
      y_aff_q    <= '0;
      inf_q      <= 1'b0;
      idx_q      <= '0;
      mul_wait_q <= 1'b0;
    end else begin
      p_q        <= p_d;
      x_q        <= x_d;
      y_q        <= y_d;
      z_q        <= z_d;
      e_q        <= e_d;
      acc_q      <= acc_d;
      t2_q       <= t2_d;
      t3_q       <= t3_d;
      x_aff_q    <= x_aff_d;
      y_aff_q    <= y_aff_d;
      inf_q      <= inf_d;
      idx_q      <= idx_d;
      mul_wait_q <= mul_wait_d;
    end
  end

  assign x_aff = x_aff_q;
  assign y_aff = y_aff_q;
  assign o_inf = inf_q;
endmodule

// File: doc/ecc_jacobian_to_affine.md
Name: ecc_jacobian_to_affine

Overview:
- Converts a Jacobian point (X, Y, Z) over GF(p) into affine coordinates: x = X·Z⁻², y = Y·Z⁻³.
- Sits on the output side of the point-addition/doubling datapath and consumes its (X3, Y3, Z3) result.
- Computes Z⁻¹ by Fermat exponentiation, Z^(p−2) mod p, using square-and-multiply.
- All multiplications run on one shared modular_multiplication instance, sequenced by an FSM.

Parameters:
- WIDTH, 256, operand and modulus width in bits.

Ports:
- i_clk     input   1      clock, all logic on rising edge
- i_rst     input   1      synchronous reset, active-high
- i_start   input   1      request; sampled only when o_busy=0
- p         input   WIDTH  prime modulus; odd, >3
- X         input   WIDTH  Jacobian X, fully reduced (<p)
- Y         input   WIDTH  Jacobian Y, fully reduced (<p)
- Z         input   WIDTH  Jacobian Z, fully reduced (<p)
- x_aff     output  WIDTH  affine x
- y_aff     output  WIDTH  affine y
- o_inf     output  1      input was the point at infinity (Z=0)
- o_busy    output  1      conversion in progress
- o_done    output  1      one-cycle completion pulse

Behaviour:
- Interface: one clock i_clk; reset i_rst is synchronous and active-high.
- Reset: FSM goes to IDLE. x_aff=0, y_aff=0, o_inf=0, o_busy=0, o_done=0. All internal registers are cleared.
- Multiplier sharing: the single modular_multiplication instance has its rst_n driven by ~i_rst and its m input by the latched p.
- Multiplier contract: the FSM drives start high for exactly one cycle with a and b stable. It ignores ready in that start cycle, then waits for ready=1 and captures the product in that cycle. Operands stay held until capture.
- Input latch: i_start while o_busy=0 latches p, X, Y, Z and E=p−2 (internal WIDTH-bit subtract). o_busy rises the next cycle. i_start while o_busy=1 is ignored; latched inputs do not change.
- FSM states:
  - IDLE: on i_start, latch inputs and go to CHK.
  - CHK:
    - If Z=0: x_aff=0, y_aff=0, o_inf=1, go to DONE.
    - Else: acc=1, bit index i=WIDTH−1, go to SQR.
  - SQR: acc←acc·acc.
    - If E[i]=1, go to MUL.
    - Else if i=0, go to ZI2.
    - Else i←i−1 and stay in SQR.
  - MUL: acc←acc·Z. If i=0 go to ZI2, else i←i−1 and go to SQR.
  - ZI2: t2←acc·acc (this is Z⁻²).
  - XA: x_aff←X·t2.
  - ZI3: t3←t2·acc (this is Z⁻³).
  - YA: y_aff←Y·t3. o_inf=0. Go to DONE.
  - DONE: o_done=1 for one cycle, o_busy=0, return to IDLE.
- Multiplication count: WIDTH squares + popcount(p−2) multiplies + 4. Latency is data-dependent and is bounded by (2·WIDTH+4)·Tmul plus a few control cycles.
- Output holding: outputs and o_inf hold their values from DONE until the next accepted start. They are not cleared at start. Intermediate values never appear on x_aff/y_aff until the XA and YA captures, and those occur only inside a busy window.
- Bit index i is a log2(WIDTH)-bit down-counter. Exit occurs at i=0; there is no wrap.
- Reset mid-operation: abort immediately, all outputs return to reset values, and no o_done is produced.
- A reset issued while the multiplier is mid-operation also resets the multiplier. The FSM must not wait on a stale ready afterwards.
- Simultaneous i_start and the DONE cycle: the start is ignored, because o_busy is still 1 in that cycle.
- Out of scope: Z ≥ p and non-prime p give undefined results. No check is performed.

Test Plan:
- p=23, X=5, Y=7, Z=2, pulse i_start → o_done pulses once; x_aff=7, y_aff=21, o_inf=0; o_busy high from the cycle after start until DONE.
- p=23, X=9, Y=4, Z=5 → x_aff=16, y_aff=5. Then re-run with Z=1, X=9, Y=4 → x_aff=9, y_aff=4.
- p=23, Z=0, X=3, Y=3 → o_done within 3 cycles of start; o_inf=1, x_aff=0, y_aff=0; zero multiplier starts observed.
- p = P-256 prime, (X, Y, Z) = generator scaled by Z=2 (X·4, Y·8 mod p) → x_aff, y_aff equal the P-256 generator Gx, Gy.
- Start a p=23 conversion and pulse i_start again mid-run with different inputs → second pulse ignored; result still matches the first inputs; exactly one o_done.
- Assert i_rst in cycle 50 of a run → all outputs 0 the next cycle, no o_done. A fresh start after release gives correct results (x_aff=7, y_aff=21 for the first vector).
